// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
//
// Reader-side checker for an enable-gated up-counter. The monitor samples the
// counter value and its enable on every rising edge. From the previous sample
// it predicts the current value as prev_cnt + prev_en, modulo 2^WIDTH. It locks
// after SYNC_LEN consecutive correct predictions. While locked, it flags and
// counts every deviation.
//
// Parameters
//   WIDTH      width of the monitored count bus
//   ERR_CNT_W  width of the saturating error counter
//   SYNC_LEN   consecutive matching samples required to lock (>= 1)
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        asynchronous, active-low reset
//   en         enable as seen by the counter under test
//   cnt_in     counter output being monitored
//   clr        synchronous clear of err_count (lock state unaffected)
//   locked     1 while in LOCK
//   err_pulse  one-cycle pulse per mismatch detected in LOCK
//   err_count  mismatches since reset/clr, saturates at all-ones
//   last_good  last sample that matched the prediction while in LOCK
//   state      00 IDLE, 01 ACQ, 10 LOCK (11 is treated as IDLE)
//
// Every output comes straight from a flop or from a decode of flops. No input
// reaches an output within the same cycle.
// -----------------------------------------------------------------------------
module count_monitor #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 16,
  parameter int SYNC_LEN  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     last_good,
  output logic [1:0]           state
);

  localparam int MC_W = (SYNC_LEN < 1) ? 1 : $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_cnt_q;
  logic                 prev_en_q;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0]     last_good_q, last_good_d;

  logic [WIDTH-1:0]     expected;
  logic                 match;

  // The counter loads out+1 on an enabled edge and holds otherwise.
  // All-ones + 1 wraps to zero, and that wrap counts as a match.
  assign expected = prev_cnt_q + WIDTH'(prev_en_q);
  assign match    = (cnt_in == expected);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    last_good_d = last_good_q;

    case (state_q)
      ACQ: begin
        if (match) begin
          match_cnt_d = match_cnt_q + MC_W'(1);
          if (match_cnt_q == MC_W'(SYNC_LEN - 1)) begin
            state_d = LOCK;
          end
        end else begin
          // Mismatches while acquiring just restart the run. They are not
          // errors because we never claimed lock.
          match_cnt_d = '0;
        end
      end

      LOCK: begin
        if (match) begin
          last_good_d = cnt_in;
        end else begin
          err_pulse_d = 1'b1;
          state_d     = ACQ;
          match_cnt_d = '0;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
        end
      end

      // IDLE, and the unused 2'b11 encoding. The first edge only captures
      // history, because there is no previous sample to predict from yet.
      default: begin
        state_d     = ACQ;
        match_cnt_d = '0;
      end
    endcase

    // Clear takes priority over a coincident increment. The pulse and the drop
    // to ACQ above still happen.
    if (clr) begin
      err_count_d = '0;
    end
  end

  // Registers.
  // NOTE: all state is cleared by the asynchronous reset. Every flop here is a
  // plain register rather than a memory, so resetting each one costs nothing
  // and gives a known power-up state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prev_cnt_q  <= '0;
      prev_en_q   <= 1'b0;
      match_cnt_q <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      last_good_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge
      // values. The history update must not leak into this edge's compare.
      state_q     <= state_d;
      prev_cnt_q  <= cnt_in;
      prev_en_q   <= en;
      match_cnt_q <= match_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      last_good_q <= last_good_d;
    end
  end

  assign locked    = (state_q == LOCK);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign last_good = last_good_q;
  assign state     = state_q;

endmodule
